seg7_scan_ctrl: RTL and testbench

// - Time-multiplexes one shared bcd7seg decoder across NDIG common-anode digit positions.
// - Takes a packed BCD word and scans it digit by digit: one digit enable active at a

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_ctrl_if.sv | 22 ++
 rtl/bcd7seg.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller and its decoder.
package seg7_pkg;

    // Segment patterns are ordered {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // A nibble is a displayable decimal digit only when it is 0..9.
    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= 4'd9);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the BCD-producing datapath and the scanned display pins.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   value;
    logic                lz_blank;
    logic [NDIG-1:0]     an;
    logic [6:0]          seg;
    logic                frame_tick;
    logic                err;

    modport master (
        output load, value, lz_blank,
        input  an, seg, frame_tick, err
    );

    modport slave (
        input  load, value, lz_blank,
        output an, seg, frame_tick, err
    );
endinterface

// File: rtl/bcd7seg.sv
// Combinational BCD to 7-segment decoder, segments {a,b,c,d,e,f,g} active-high.
module bcd7seg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Plain lookup; codes above 9 show a dash so a bad digit is never mistaken for a number.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = 7'b1111110;
            4'd1:    seg_o = 7'b0110000;
            4'd2:    seg_o = 7'b1101101;
            4'd3:    seg_o = 7'b1111001;
            4'd4:    seg_o = 7'b0110011;
            4'd5:    seg_o = 7'b1011011;
            4'd6:    seg_o = 7'b1011111;
            4'd7:    seg_o = 7'b1110000;
            4'd8:    seg_o = 7'b1111111;
            4'd9:    seg_o = 7'b1111011;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans a packed BCD word across NDIG common-anode digits through one shared decoder,
// with a blanking guard between digits and tear-free commits at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NDIG);
    localparam int VW      = 4 * NDIG;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [NDIG-1:0]   an_q;
    logic [6:0]        seg_q;
    logic              frameTick_q;
    logic              err_q;
    logic [VW-1:0]     active_q;
    logic [VW-1:0]     pending_q;
    logic              pendValid_q;

    logic [VW-1:0]     upperWord;
    logic [3:0]        nibble;
    logic              upperZero;
    logic [6:0]        decSeg;
    logic [6:0]        showSeg;
    logic [NDIG-1:0]   anOneHot;
    logic              wrapEdge;
    logic [VW-1:0]     active_d;
    logic              err_d;

    // The current digit and everything above it, so leading-zero detection is one compare.
    always_comb begin
        upperWord = active_q >> {idx_q, 2'b00};
        nibble    = upperWord[3:0];
        upperZero = (upperWord == '0);
        anOneHot  = {{(NDIG-1){1'b0}}, 1'b1} << idx_q;
    end

    bcd7seg uDecoder (
        .bcd_i (nibble),
        .seg_o (decSeg)
    );

    // Pattern for the digit about to be lit: invalid digits dash, leading zeros go dark.
    always_comb begin
        showSeg = decSeg;
        if (!bcd_valid(nibble)) begin
            showSeg = SEG_DASH;
        end else if (bus.lz_blank && (idx_q != '0) && upperZero) begin
            showSeg = SEG_BLANK;
        end
    end

    // The last SHOW cycle of the last digit is the only place a new word may take effect.
    always_comb begin
        wrapEdge = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);
        active_d = active_q;
        if (wrapEdge) begin
            if (bus.load) begin
                active_d = bus.value;
            end else if (pendValid_q) begin
                active_d = pending_q;
            end
        end
    end

    // Error flag reflects the word that will be on display after the commit.
    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!bcd_valid(active_d[4*i +: 4])) begin
                err_d = 1'b1;
            end
        end
    end

    // Scan FSM: alternate a dark guard and a lit dwell per digit, outputs registered with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            an_q        <= '0;
            seg_q       <= SEG_BLANK;
            frameTick_q <= 1'b0;
        end else begin
            frameTick_q <= 1'b0;
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ST_SHOW;
                        cnt_q   <= '0;
                        an_q    <= anOneHot;
                        seg_q   <= showSeg;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_q     <= ST_BLANK;
                        cnt_q       <= '0;
                        an_q        <= '0;
                        seg_q       <= SEG_BLANK;
                        idx_q       <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        frameTick_q <= (idx_q == IDX_LAST);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pending/active double buffer: loads park in pending, the frame wrap moves them to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= '0;
            pending_q   <= '0;
            pendValid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (bus.load) begin
                pending_q <= bus.value;
            end
            if (wrapEdge) begin
                active_q    <= active_d;
                err_q       <= err_d;
                pendValid_q <= 1'b0;
            end else if (bus.load) begin
                pendValid_q <= 1'b1;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frameTick_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=4, BLANK_CYC=1 (20-cycle frames).
module tb_seg7_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;
    localparam int SLOT      = BLANK_CYC + DIV;
    localparam int FRAME     = NDIG * SLOT;

    localparam logic [6:0] P0   = 7'b1111110;
    localparam logic [6:0] P1   = 7'b0110000;
    localparam logic [6:0] P2   = 7'b1101101;
    localparam logic [6:0] P3   = 7'b1111001;
    localparam logic [6:0] P4   = 7'b0110011;
    localparam logic [6:0] P5   = 7'b1011011;
    localparam logic [6:0] P7   = 7'b1110000;
    localparam logic [6:0] P9   = 7'b1111011;
    localparam logic [6:0] DASH = 7'b0000001;
    localparam logic [6:0] OFF  = 7'b0000000;

    // One record per frame: inputs driven during it and the display expected in it.
    typedef struct {
        string             name;
        logic              lz;
        int                loadAt;
        logic [15:0]       val;
        int                loadAt2;
        logic [15:0]       val2;
        logic [3:0][6:0]   expSeg;
        logic              expErr;
    } frame_t;

    logic   clk;
    logic   rst;
    int     compared   = 0;
    int     mismatched = 0;
    frame_t tbl[10];
    frame_t zeroFrame;

    seg7_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    seg7_scan_ctrl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the scan never comes back.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic lz);
        bus.load     = ld;
        bus.value    = val;
        bus.lz_blank = lz;
    endtask

    task automatic checkOutput(input string name, input int p, input logic [3:0] expAn,
                               input logic [6:0] expSeg, input logic expTick, input logic expErr);
        compared++;
        if (bus.an !== expAn || bus.seg !== expSeg || bus.frame_tick !== expTick || bus.err !== expErr) begin
            mismatched++;
            $display("[TB] FAIL %s p=%0d: an=%b seg=%b tick=%b err=%b, want an=%b seg=%b tick=%b err=%b",
                     name, p, bus.an, bus.seg, bus.frame_tick, bus.err, expAn, expSeg, expTick, expErr);
        end
    endtask

    // Walks one frame cycle by cycle, starting on the cycle right after the wrap edge.
    task automatic checkFrame(input frame_t f, input logic tick0);
        logic [3:0] expAn;
        logic [6:0] expSeg;
        for (int p = 0; p < FRAME; p++) begin
            if (p > 0) @(negedge clk);
            if (p == f.loadAt)       applyStimulus(1'b1, f.val, f.lz);
            else if (p == f.loadAt2) applyStimulus(1'b1, f.val2, f.lz);
            else                     applyStimulus(1'b0, bus.value, f.lz);
            if (p % SLOT == 0) begin
                expAn  = 4'b0000;
                expSeg = OFF;
            end else begin
                expAn  = 4'b0001 << (p / SLOT);
                expSeg = f.expSeg[p / SLOT];
            end
            checkOutput(f.name, p, expAn, expSeg, (p == 0) ? tick0 : 1'b0, f.expErr);
        end
    endtask

    // Advances to the cycle carrying frame_tick; a missing tick is itself a failure.
    task automatic waitFrameTick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, bus.value, bus.lz_blank);
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL frameTickTimeout: tick=%b, want 1", bus.frame_tick);
        end
    endtask

    initial begin
        zeroFrame = '{name:"zeros", lz:1'b0, loadAt:-1, val:16'h0, loadAt2:-1, val2:16'h0,
                      expSeg:{P0, P0, P0, P0}, expErr:1'b0};

        tbl[0] = '{name:"idleLoad1234",  lz:1'b0, loadAt:7,  val:16'h1234, loadAt2:-1, val2:16'h0,
                   expSeg:{P0, P0, P0, P0},       expErr:1'b0};
        tbl[1] = '{name:"show1234",      lz:1'b0, loadAt:5,  val:16'h0070, loadAt2:-1, val2:16'h0,
                   expSeg:{P1, P2, P3, P4},       expErr:1'b0};
        tbl[2] = '{name:"lz0070",        lz:1'b1, loadAt:12, val:16'h0000, loadAt2:-1, val2:16'h0,
                   expSeg:{OFF, OFF, P7, P0},     expErr:1'b0};
        tbl[3] = '{name:"lz0000",        lz:1'b1, loadAt:2,  val:16'h12A4, loadAt2:-1, val2:16'h0,
                   expSeg:{OFF, OFF, OFF, P0},    expErr:1'b0};
        tbl[4] = '{name:"bad12A4",       lz:1'b0, loadAt:8,  val:16'h1234, loadAt2:-1, val2:16'h0,
                   expSeg:{P1, P2, DASH, P4},     expErr:1'b1};
        tbl[5] = '{name:"recover1234",   lz:1'b0, loadAt:3,  val:16'h1111, loadAt2:9,  val2:16'h2222,
                   expSeg:{P1, P2, P3, P4},       expErr:1'b0};
        tbl[6] = '{name:"lastWins2222",  lz:1'b0, loadAt:19, val:16'h5555, loadAt2:-1, val2:16'h0,
                   expSeg:{P2, P2, P2, P2},       expErr:1'b0};
        tbl[7] = '{name:"bypass5555",    lz:1'b0, loadAt:-1, val:16'h0,    loadAt2:-1, val2:16'h0,
                   expSeg:{P5, P5, P5, P5},       expErr:1'b0};
        tbl[8] = '{name:"hold5555",      lz:1'b1, loadAt:4,  val:16'h0905, loadAt2:-1, val2:16'h0,
                   expSeg:{P5, P5, P5, P5},       expErr:1'b0};
        tbl[9] = '{name:"lzInner0905",   lz:1'b1, loadAt:-1, val:16'h0,    loadAt2:-1, val2:16'h0,
                   expSeg:{OFF, P9, P0, P5},      expErr:1'b0};

        // Power-up reset, then the first frame runs from the reset state without a tick.
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 4'b0000, OFF, 1'b0, 1'b0);
        rst = 1'b0;
        zeroFrame.name = "firstFrame";
        checkFrame(zeroFrame, 1'b0);

        for (int i = 0; i < 10; i++) begin
            waitFrameTick();
            checkFrame(tbl[i], 1'b1);
        end

        // Reset while digit 2 is lit with a load pending; a load during reset must not stick.
        waitFrameTick();
        for (int p = 1; p <= 12; p++) begin
            @(negedge clk);
            applyStimulus(p == 2, 16'h7777, 1'b1);
        end
        checkOutput("preReset", 12, 4'b0100, P9, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h8888, 1'b0);
        #1;
        checkOutput("asyncReset", 12, 4'b0000, OFF, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h8888, 1'b0);
        rst = 1'b0;
        zeroFrame.name = "postReset";
        checkFrame(zeroFrame, 1'b0);
        waitFrameTick();
        zeroFrame.name = "pendingDropped";
        checkFrame(zeroFrame, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
